// File: rtl/ub_deskew_writeback.sv
// ub_deskew_writeback: re-aligns the skewed array output lanes into rows and writes them to the UB
module ub_deskew_writeback #(
  parameter int ARRAY_SIZE   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int BUFFER_WIDTH = ARRAY_SIZE * DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_in_flat,
  input  logic                             first_in,
  input  logic                             last_in,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [BUFFER_WIDTH-1:0]          wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  localparam int N = ARRAY_SIZE;
  typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, wa_q, wa_d;
  logic                  we_q, we_d, done_q, done_d, busy_q, busy_d, err_q, err_d, rv_q, rv_d;
  logic [N-2:0]          f_q, l_q;
  logic                  af, al, row;
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] sh_q [N-i];
    // lane i lags lane 0 by i cycles, so it gets N-i stages; the last one drives wr_data
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s < N-i; s++) sh_q[s] <= '0;
      end else if (en) begin
        sh_q[0] <= data_in_flat[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH];
        for (int s = 1; s < N-i; s++) sh_q[s] <= sh_q[s-1];
      end
    end
    assign wr_data[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] = sh_q[N-1-i];
  end
  // markers ride N-1 stages; the registered write outputs form their final, aligned stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q <= '0;
      l_q <= '0;
    end else if (en) begin
      f_q[0] <= first_in;
      l_q[0] <= last_in;
      for (int s = 1; s < N-1; s++) begin
        f_q[s] <= f_q[s-1];
        l_q[s] <= l_q[s-1];
      end
    end
  end
  assign af  = f_q[N-2];
  assign al  = l_q[N-2];
  assign row = af | rv_q;
  // control state and registered write-port outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wa_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
    end
  end
  // next state: arm on start, write each aligned row, finish on the aligned last marker
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wa_d    = wa_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    rv_d    = rv_q;
    if (en) begin
      rv_d = row & ~al;
      if (state_q == IDLE && start) begin
        state_d = ARMED;
        addr_d  = base_addr;
        err_d   = 1'b0;
      end
      if ((state_q == ARMED && af) || (state_q == WRITE && row)) begin
        we_d    = 1'b1;
        wa_d    = addr_q;
        addr_d  = addr_q + 1'b1;
        done_d  = al;
        state_d = al ? IDLE : WRITE;
      end
      if (state_q == WRITE && af) err_d = 1'b1;
    end
    busy_d = (state_d != IDLE) | done_d;
  end
  assign wr_en   = we_q;
  assign wr_addr = wa_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_ub_deskew_writeback.sv
// tb_ub_deskew_writeback: directed scenarios for the deskew/writeback block
module tb_ub_deskew_writeback;
  logic        clk = 0, rst_n = 0, en = 0, start = 0, first_in = 0, last_in = 0;
  logic [7:0]  base_addr = '0;
  logic [31:0] data_in = '0;
  logic        wr_en, busy, done, err;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  int          checks = 0, errors = 0, cyc = 0;
  int          nw = 0, nd = 0, wc [64];
  logic [7:0]  wa [64];
  logic [31:0] wd [64];
  logic        wdn [64];
  logic        db = 0, pb = 0, pd = 0;

  ub_deskew_writeback #(.ARRAY_SIZE(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .BUFFER_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .base_addr(base_addr),
    .data_in_flat(data_in), .first_in(first_in), .last_in(last_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write log, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en && nw < 64) begin
      wa[nw] = wr_addr; wd[nw] = wr_data; wc[nw] = cyc; wdn[nw] = done; nw++;
    end
    if (done) begin nd++; db = busy; end
    if (pd) pb = busy;
    pd = done;
  end

  function automatic logic [31:0] skew(input int k, input int rows);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < 4; c++)
      if (k - c >= 0 && k - c < rows) v[c*8 +: 8] = 8'((k - c) * 16 + c);
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic stream(input int rows, input bit st, input logic [7:0] base, input int stall_at,
                        input int stall_len, input int dup_first, input int start2, input int max_p,
                        output int t0);
    int k;
    k = 0; t0 = cyc;
    for (int p = 0; p < rows + 6 + stall_len && p < max_p; p++) begin
      if (stall_at >= 0 && p >= stall_at && p < stall_at + stall_len) begin
        en = 0; data_in = 32'hDEADBEEF; first_in = 1; last_in = 1; start = 0;
      end else begin
        if (k == 0) t0 = cyc;
        en = 1; data_in = skew(k, rows);
        first_in = (k == 0) || (k == dup_first); last_in = (k == rows - 1);
        start = (st && k == 0) || (k == start2);
        base_addr = (k == start2) ? 8'h50 : base;
        k++;
      end
      @(posedge clk); #1;
    end
    en = 1; start = 0; first_in = 0; last_in = 0; data_in = '0;
  endtask

  task automatic test_reset;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_basic;
    int n0, d0, t0;
    logic [31:0] ed [3];
    ed[0] = 32'h03020100; ed[1] = 32'h13121110; ed[2] = 32'h23222120;
    n0 = nw; d0 = nd;
    stream(3, 1, 8'h10, -1, 0, -1, -1, 1000, t0);
    checks++; if (nw - n0 !== 3) begin errors++; $display("FAIL basic_count: got %0d want 3", nw - n0); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (wa[n0+j] !== 8'(8'h10 + j)) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", j, wa[n0+j], 8'(8'h10 + j)); end
      checks++; if (wd[n0+j] !== ed[j]) begin errors++; $display("FAIL basic_data%0d: got %h want %h", j, wd[n0+j], ed[j]); end
      checks++; if (wc[n0+j] - t0 !== 4 + j) begin errors++; $display("FAIL basic_lat%0d: got %0d want %0d", j, wc[n0+j] - t0, 4 + j); end
      checks++; if (wdn[n0+j] !== (j == 2)) begin errors++; $display("FAIL basic_done%0d: got %b want %b", j, wdn[n0+j], j == 2); end
    end
    checks++; if (nd - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", nd - d0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
  endtask

  task automatic test_single;
    int n0, t0;
    n0 = nw;
    stream(1, 1, 8'h05, -1, 0, -1, -1, 1000, t0);
    checks++; if (nw - n0 !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", nw - n0); end
    checks++; if (wa[n0] !== 8'h05) begin errors++; $display("FAIL single_addr: got %h want 05", wa[n0]); end
    checks++; if (wd[n0] !== 32'h03020100) begin errors++; $display("FAIL single_data: got %h want 03020100", wd[n0]); end
    checks++; if (wdn[n0] !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", wdn[n0]); end
    checks++; if (db !== 1'b1) begin errors++; $display("FAIL single_busy_at_done: got %b want 1", db); end
    checks++; if (pb !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", pb); end
  endtask

  task automatic test_stall;
    int n0, t0;
    n0 = nw;
    stream(3, 1, 8'h20, 2, 2, -1, -1, 1000, t0);
    checks++; if (nw - n0 !== 3) begin errors++; $display("FAIL stall_count: got %0d want 3", nw - n0); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (wa[n0+j] !== 8'(8'h20 + j)) begin errors++; $display("FAIL stall_addr%0d: got %h want %h", j, wa[n0+j], 8'(8'h20 + j)); end
      checks++; if (wc[n0+j] - t0 !== 6 + j) begin errors++; $display("FAIL stall_lat%0d: got %0d want %0d", j, wc[n0+j] - t0, 6 + j); end
    end
    checks++; if (wd[n0+1] !== 32'h13121110) begin errors++; $display("FAIL stall_data1: got %h want 13121110", wd[n0+1]); end
  endtask

  task automatic test_wrap;
    int n0, t0;
    n0 = nw;
    stream(2, 1, 8'hFF, -1, 0, -1, -1, 1000, t0);
    checks++; if (nw - n0 !== 2) begin errors++; $display("FAIL wrap_count: got %0d want 2", nw - n0); end
    checks++; if (wa[n0] !== 8'hFF) begin errors++; $display("FAIL wrap_addr0: got %h want FF", wa[n0]); end
    checks++; if (wa[n0+1] !== 8'h00) begin errors++; $display("FAIL wrap_addr1: got %h want 00", wa[n0+1]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err); end
  endtask

  task automatic test_no_start;
    int n0, d0, t0;
    n0 = nw; d0 = nd;
    stream(3, 0, 8'h10, -1, 0, -1, -1, 1000, t0);
    checks++; if (nw - n0 !== 0) begin errors++; $display("FAIL nostart_writes: got %0d want 0", nw - n0); end
    checks++; if (nd - d0 !== 0) begin errors++; $display("FAIL nostart_done: got %0d want 0", nd - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nostart_busy: got %b want 0", busy); end
  endtask

  task automatic test_restart_ignored;
    int n0, t0;
    n0 = nw;
    stream(3, 1, 8'h30, -1, 0, -1, 2, 1000, t0);
    checks++; if (nw - n0 !== 3) begin errors++; $display("FAIL restart_count: got %0d want 3", nw - n0); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (wa[n0+j] !== 8'(8'h30 + j)) begin errors++; $display("FAIL restart_addr%0d: got %h want %h", j, wa[n0+j], 8'(8'h30 + j)); end
    end
  endtask

  task automatic test_dup_first;
    int n0, d0, t0;
    n0 = nw; d0 = nd;
    stream(4, 1, 8'h40, -1, 0, 2, -1, 1000, t0);
    checks++; if (nw - n0 !== 4) begin errors++; $display("FAIL dup_count: got %0d want 4", nw - n0); end
    checks++; if (wa[n0+3] !== 8'h43) begin errors++; $display("FAIL dup_addr3: got %h want 43", wa[n0+3]); end
    checks++; if (nd - d0 !== 1) begin errors++; $display("FAIL dup_done: got %0d want 1", nd - d0); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL dup_err_set: got %b want 1", err); end
    idle(5);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL dup_err_sticky: got %b want 1", err); end
    n0 = nw;
    stream(1, 1, 8'h60, -1, 0, -1, -1, 1000, t0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL dup_err_clear: got %b want 0", err); end
    checks++; if (wa[n0] !== 8'h60) begin errors++; $display("FAIL dup_next_addr: got %h want 60", wa[n0]); end
  endtask

  task automatic test_reset_mid;
    int n0, d0, t0;
    n0 = nw; d0 = nd;
    stream(4, 1, 8'h70, -1, 0, -1, -1, 4, t0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL rmid_wr_addr: got %h want 00", wr_addr); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL rmid_wr_data: got %h want 0", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
    idle(8);
    checks++; if (nw - n0 !== 1) begin errors++; $display("FAIL rmid_writes: got %0d want 1", nw - n0); end
    checks++; if (wa[n0] !== 8'h70) begin errors++; $display("FAIL rmid_addr0: got %h want 70", wa[n0]); end
    checks++; if (nd - d0 !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d want 0", nd - d0); end
    n0 = nw; d0 = nd;
    stream(2, 1, 8'h80, -1, 0, -1, -1, 1000, t0);
    checks++; if (nw - n0 !== 2) begin errors++; $display("FAIL rmid_fresh_count: got %0d want 2", nw - n0); end
    checks++; if (wa[n0+1] !== 8'h81) begin errors++; $display("FAIL rmid_fresh_addr1: got %h want 81", wa[n0+1]); end
    checks++; if (nd - d0 !== 1) begin errors++; $display("FAIL rmid_fresh_done: got %0d want 1", nd - d0); end
  endtask

  initial begin
    idle(3);
    test_reset;
    rst_n = 1;
    en = 1;
    idle(2);
    test_basic;
    test_single;
    test_stall;
    test_wrap;
    test_no_start;
    test_restart_ignored;
    test_dup_first;
    test_reset_mid;
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ub_deskew_writeback.md
# ub_deskew_writeback

Output-side counterpart of the UB input/weight skewer path. It takes the diagonally skewed result stream leaving the bottom of the systolic array, where lane i lags lane 0 by i cycles. It re-aligns the lanes into full rows and writes each row into the unified buffer write port at consecutive addresses from a programmed base. A small control FSM arms on `start`, frames the transfer with the stream's first/last markers, and pulses `done` after the final row is written.

## Interface
Parameters:
- `N`, `ARRAY_SIZE`, number of lanes (array columns)
- `DATA_WIDTH`, `DATA_WIDTH`, bits per lane
- `ADDR_WIDTH`, `ADDR_WIDTH`, UB address width
- `BUFFER_WIDTH`, `BUFFER_WIDTH`, UB word width; must equal N*DATA_WIDTH

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `en` in 1: global advance; when low, the block is frozen
- `start` in 1: one-cycle arm request
- `base_addr` in ADDR_WIDTH: first write address, latched on accepted `start`
- `data_in_flat` in N*DATA_WIDTH: skewed lanes; lane i = bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- `first_in` in 1: first row marker, aligned with lane 0 of that row
- `last_in` in 1: last row marker, aligned with lane 0 of that row
- `wr_en` out 1: UB write strobe
- `wr_addr` out ADDR_WIDTH: UB write address
- `wr_data` out BUFFER_WIDTH: de-skewed row, same lane packing as input
- `busy` out 1: high in ARMED and WRITE
- `done` out 1: one-cycle pulse after the last row is written
- `err` out 1: sticky protocol error, cleared only by reset or accepted `start`

## Operation
- Deskew: lane i passes through N-i registers; markers pass through N registers. The last stage is the output register feeding `wr_data`. A row whose lane 0 is sampled at cycle t appears aligned at t+N.
- Rows are contiguous: every `en` cycle from `first_in` through `last_in` inclusive carries one row. Cycles outside a first..last window carry no row.
- Internal `row_valid` is set by the aligned first marker and cleared after the aligned last marker. It travels at aligned timing.
- FSM states:
  - IDLE → ARMED on `start`; latch `addr_cnt <= base_addr` and clear `err`.
  - ARMED → WRITE when the aligned first marker arrives. That row is written to `base_addr`.
  - In WRITE, each aligned row is written to `addr_cnt`, then `addr_cnt` increments.
  - WRITE → IDLE when the aligned last marker is written; `done` pulses in the same cycle as that write.
  - If aligned first and last coincide (single-row stream): one write, ARMED → IDLE directly, `done` pulses.
- Rows arriving while IDLE are deskewed but never written (no `wr_en`).
- `start` while `busy` is ignored; it does not change `base_addr`.
- Aligned first marker while in WRITE: set `err`, continue the current transfer unchanged, and do not reset the address.
- `addr_cnt` wraps modulo 2^ADDR_WIDTH with no flag.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - all delay registers, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `err` become 0; FSM goes to IDLE.
  - A reset mid-transfer aborts it: no further writes and no `done`.
- Latency: `first_in` lane 0 sampled at cycle t → `wr_en`=1 with that row at cycle t+N (continuous `en`). `wr_en`/`wr_addr`/`wr_data` are registered.
- `en`=0 stall:
  - inputs are not sampled and delay lines, `addr_cnt` and the FSM hold.
  - `wr_en` and `done` are 0 during stall cycles. The pending row is written in the first cycle after `en` returns high, never twice.
  - Stall cycles do not count toward latency.
- `start` is accepted when `en`=1 and the FSM is IDLE. The earliest usable `first_in` is in the same cycle as `start`.
- `done` and the final `wr_en` share a cycle; `busy` falls the following cycle.

## Test plan
- N=4, DATA_WIDTH=8, base 0x10: `start`, then 3 skewed rows with lane values {r,c} = 8'h(r*16+c) → writes at cycles t+4..t+6, addr 0x10/0x11/0x12, `wr_data` row0 = 32'h03020100, `done` with the third write.
- Single row, `first_in`=`last_in`=1, base 0x05 → exactly one write to 0x05, `done` in the same cycle, `busy` 0 next cycle.
- `en` held low for 2 cycles mid-stream (stream re-skewed accordingly) → no duplicate or dropped rows, addresses contiguous, latency shifted by 2.
- Base 2^ADDR_WIDTH-1 with 2 rows → writes at max address then 0, no `err`.
- Rows with no `start` → no `wr_en`. Second `start` while busy → ignored and the original base is retained. Extra `first_in` mid-transfer → `err`=1, which stays set until the next accepted `start`.
- `rst_n` low for 1 cycle after 1 of 4 rows → all outputs 0, FSM in IDLE, no `done`; a fresh `start` then completes normally.
